// File: rtl/cdc_pkg.sv
// cdc_pkg: shared constants and helpers for the clock-domain-crossing synchronizers
//   CDC_MIN_STAGES  smallest legal sync chain depth
//   cdc_cnt_w(n)    width of a counter that must hold values 0..n
package cdc_pkg;
    localparam int CDC_MIN_STAGES = 2;
    function automatic int cdc_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/cdc_sync_filt_bit.sv
// cdc_sync_filt_bit: one channel of the level synchronizer (sync chain, glitch filter, edge detect, sticky flags)
//   clk, rst_n       destination clock, asynchronous active-low reset
//   i_sig            asynchronous level input
//   i_clr            synchronous clear of both sticky flags
//   o_sig_sync       synchronized, filtered level
//   o_rise/o_fall    one-cycle edge pulses of o_sig_sync
//   o_rise_sticky    latched o_rise until i_clr
//   o_fall_sticky    latched o_fall until i_clr
module cdc_sync_filt_bit
    import cdc_pkg::*;
#(
    parameter int   STAGES      = 2,
    parameter logic RST_VAL     = 1'b0,
    parameter int   FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    input  logic i_clr,
    output logic o_sig_sync,
    output logic o_rise,
    output logic o_fall,
    output logic o_rise_sticky,
    output logic o_fall_sticky
);
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic s, f, p_q, rise_sticky_q, rise_sticky_d, fall_sticky_q, fall_sticky_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {STAGES{RST_VAL}};
        else        sync_q <= {sync_q[STAGES-2:0], i_sig};
    end
    assign s = sync_q[STAGES-1];
    generate
        if (FILT_CYCLES == 0) begin : g_bypass
            assign f = s;
        end else begin : g_filt
            localparam int CW = cdc_cnt_w(FILT_CYCLES);
            localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES - 1);
            logic [CW-1:0] cnt_q, cnt_d;
            logic f_q, f_d;
            // A disagreement run resets the count the moment s agrees with f again,
            // so only FILT_CYCLES consecutive differing samples move the output.
            always_comb begin
                cnt_d = (s != f_q && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : '0;
                f_d   = (s != f_q && cnt_q == CNT_MAX) ? s : f_q;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    f_q   <= RST_VAL;
                end else begin
                    cnt_q <= cnt_d;
                    f_q   <= f_d;
                end
            end
            assign f = f_q;
        end
    endgenerate
    // p resets to the same value as f so reset release never looks like an edge.
    assign o_sig_sync    = f;
    assign o_rise        = f & ~p_q;
    assign o_fall        = ~f & p_q;
    assign o_rise_sticky = rise_sticky_q;
    assign o_fall_sticky = fall_sticky_q;
    always_comb begin
        rise_sticky_d = o_rise | (~i_clr & rise_sticky_q);
        fall_sticky_d = o_fall | (~i_clr & fall_sticky_q);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q           <= RST_VAL;
            rise_sticky_q <= 1'b0;
            fall_sticky_q <= 1'b0;
        end else begin
            p_q           <= f;
            rise_sticky_q <= rise_sticky_d;
            fall_sticky_q <= fall_sticky_d;
        end
    end
endmodule

// File: rtl/cdc_sync_filt.sv
// cdc_sync_filt: WIDTH independent asynchronous levels synchronized into clk with optional glitch filter and edge flags
//   clk, rst_n       destination clock, asynchronous active-low reset
//   i_sig[W]         asynchronous level inputs
//   i_clr[W]         per-channel synchronous sticky clear
//   o_sig_sync[W]    synchronized, filtered levels
//   o_rise/o_fall[W] one-cycle edge pulses
//   o_rise_sticky[W], o_fall_sticky[W]  latched edges, cleared by i_clr
//   o_chg_any        any edge pulse on any channel this cycle
module cdc_sync_filt
    import cdc_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RST_VAL     = '0,
    parameter int               FILT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_sig,
    input  logic [WIDTH-1:0] i_clr,
    output logic [WIDTH-1:0] o_sig_sync,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic [WIDTH-1:0] o_rise_sticky,
    output logic [WIDTH-1:0] o_fall_sticky,
    output logic             o_chg_any
);
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("cdc_sync_filt: WIDTH must be >= 1");
        end
        if (STAGES < CDC_MIN_STAGES) begin : g_bad_stages
            $error("cdc_sync_filt: STAGES must be >= %0d", CDC_MIN_STAGES);
        end
        if (FILT_CYCLES < 0) begin : g_bad_filt
            $error("cdc_sync_filt: FILT_CYCLES must be >= 0");
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            cdc_sync_filt_bit #(
                .STAGES      (STAGES),
                .RST_VAL     (RST_VAL[i]),
                .FILT_CYCLES (FILT_CYCLES)
            ) u_bit (
                .clk           (clk),
                .rst_n         (rst_n),
                .i_sig         (i_sig[i]),
                .i_clr         (i_clr[i]),
                .o_sig_sync    (o_sig_sync[i]),
                .o_rise        (o_rise[i]),
                .o_fall        (o_fall[i]),
                .o_rise_sticky (o_rise_sticky[i]),
                .o_fall_sticky (o_fall_sticky[i])
            );
        end
    endgenerate
    assign o_chg_any = |(o_rise | o_fall);
endmodule

// File: tb/tb_cdc_sync_filt.sv
// tb_cdc_sync_filt: self-checking bench for cdc_sync_filt (filtered, bypass and non-zero reset-value configurations)
module tb_cdc_sync_filt;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    logic [7:0] sig_a, clr_a, sync_a, rise_a, fall_a, rs_a, fs_a;
    logic [7:0] sig_b, clr_b, sync_b, rise_b, fall_b, rs_b, fs_b;
    logic [7:0] sig_r, clr_r, sync_r, rise_r, fall_r, rs_r, fs_r;
    logic chg_a, chg_b, chg_r;

    cdc_sync_filt #(.WIDTH(8), .STAGES(2), .RST_VAL(8'h00), .FILT_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_sig(sig_a), .i_clr(clr_a), .o_sig_sync(sync_a),
        .o_rise(rise_a), .o_fall(fall_a), .o_rise_sticky(rs_a), .o_fall_sticky(fs_a), .o_chg_any(chg_a));
    cdc_sync_filt #(.WIDTH(8), .STAGES(3), .RST_VAL(8'h00), .FILT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_sig(sig_b), .i_clr(clr_b), .o_sig_sync(sync_b),
        .o_rise(rise_b), .o_fall(fall_b), .o_rise_sticky(rs_b), .o_fall_sticky(fs_b), .o_chg_any(chg_b));
    cdc_sync_filt #(.WIDTH(8), .STAGES(2), .RST_VAL(8'hA5), .FILT_CYCLES(4)) dut_r (
        .clk(clk), .rst_n(rst_n), .i_sig(sig_r), .i_clr(clr_r), .o_sig_sync(sync_r),
        .o_rise(rise_r), .o_fall(fall_r), .o_rise_sticky(rs_r), .o_fall_sticky(fs_r), .o_chg_any(chg_r));

    int vectors = 0;
    int miscompares = 0;

    typedef struct { logic [7:0] f, p, rs, fs; } mstate_t;
    typedef struct { logic sig, clr; logic [4:0] exp; } row_t;
    mstate_t m_a, m_b;
    logic [7:0] h_a[$], h_b[$];
    row_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the synced level seen just before an edge is the input
    // sampled STAGES edges earlier; the output flips once the last FILT_CYCLES of
    // those samples all disagree with it.
    task automatic m_reset();
        m_a = '{default: '0};
        m_b = '{default: '0};
        h_a.delete();
        h_b.delete();
        repeat (8) begin
            h_a.push_back(8'h00);
            h_b.push_back(8'h00);
        end
    endtask

    task automatic m_step(input int s_n, input int f_n, input logic [7:0] h[$],
                          input logic [7:0] clr, inout mstate_t m);
        logic [7:0] nf;
        logic [7:0] rise;
        logic [7:0] fall;
        int n;
        n = h.size();
        rise = m.f & ~m.p;
        fall = ~m.f & m.p;
        m.rs = rise | (m.rs & ~clr);
        m.fs = fall | (m.fs & ~clr);
        nf = m.f;
        if (f_n == 0) nf = h[n - s_n];
        else begin
            for (int b = 0; b < 8; b++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int j = 0; j < f_n; j++)
                    if (h[n - 1 - s_n - j][b] == m.f[b]) all_diff = 1'b0;
                if (all_diff) nf[b] = ~m.f[b];
            end
        end
        m.p = m.f;
        m.f = nf;
    endtask

    function automatic logic [39:0] m_out(input mstate_t m);
        return {m.f, m.f & ~m.p, ~m.f & m.p, m.rs, m.fs};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            h_a.push_back(sig_a);
            h_b.push_back(sig_b);
            if (h_a.size() > 16) void'(h_a.pop_front());
            if (h_b.size() > 16) void'(h_b.pop_front());
            m_step(2, 4, h_a, clr_a, m_a);
            m_step(3, 0, h_b, clr_b, m_b);
        end
        #1;
        check("a_out", 64'({sync_a, rise_a, fall_a, rs_a, fs_a}), 64'(m_out(m_a)));
        check("a_chg", 64'(chg_a), 64'(|(m_a.f ^ m_a.p)));
        check("b_out", 64'({sync_b, rise_b, fall_b, rs_b, fs_b}), 64'(m_out(m_b)));
        check("b_chg", 64'(chg_b), 64'(|(m_b.f ^ m_b.p)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rc, fc, sc;
        logic [7:0] mask;
        // Bypass channel 7, STAGES=3: {sig, clr, {sync, rise, fall, rise_sticky, fall_sticky}}
        tbl[0]  = '{1'b1, 1'b0, 5'b00000};
        tbl[1]  = '{1'b1, 1'b0, 5'b00000};
        tbl[2]  = '{1'b1, 1'b0, 5'b11000};
        tbl[3]  = '{1'b1, 1'b0, 5'b10010};
        tbl[4]  = '{1'b0, 1'b0, 5'b10010};
        tbl[5]  = '{1'b0, 1'b0, 5'b10010};
        tbl[6]  = '{1'b0, 1'b0, 5'b00110};
        tbl[7]  = '{1'b0, 1'b1, 5'b00001};
        tbl[8]  = '{1'b1, 1'b1, 5'b00000};
        tbl[9]  = '{1'b1, 1'b0, 5'b00000};
        tbl[10] = '{1'b1, 1'b0, 5'b11000};
        tbl[11] = '{1'b1, 1'b0, 5'b10010};

        rst_n = 1'b0;
        sig_a = '0; clr_a = '0; sig_b = '0; clr_b = '0; sig_r = 8'hA5; clr_r = '0;
        m_reset();
        repeat (3) tick();
        check("r_rst_sync", 64'(sync_r), 64'(8'hA5));
        rst_n = 1'b1;

        // Non-zero reset value held on the input: no edge after release.
        for (int k = 0; k < 20; k++) begin
            tick();
            check("r_sync", 64'(sync_r), 64'(8'hA5));
            check("r_edges", 64'({rise_r, fall_r, chg_r}), 64'(0));
        end

        for (int k = 0; k < 12; k++) begin
            sig_b[7] = tbl[k].sig;
            clr_b[7] = tbl[k].clr;
            tick();
            check("b_tbl", 64'({sync_b[7], rise_b[7], fall_b[7], rs_b[7], fs_b[7]}), 64'(tbl[k].exp));
        end
        clr_b = '0;

        // Clean step on channel 0: STAGES+FILT_CYCLES edges.
        sig_a[0] = 1'b1;
        n = 0;
        while (!sync_a[0] && n < 20) begin
            tick();
            n++;
        end
        check("step_latency", 64'(n), 64'(6));
        check("step_rise", 64'(rise_a[0]), 64'(1));
        tick();
        check("step_rise_width", 64'(rise_a[0]), 64'(0));
        check("step_sticky", 64'(rs_a[0]), 64'(1));

        // Channel 3: 3-cycle glitch is swallowed; 5-cycle pulse passes both edges.
        rc = 0; fc = 0; sc = 0;
        for (int k = 0; k < 13; k++) begin
            sig_a[3] = (k < 3);
            tick();
            rc += int'(rise_a[3]); fc += int'(fall_a[3]); sc += int'(sync_a[3]);
        end
        check("glitch3_blocked", 64'({rc[7:0], fc[7:0], sc[7:0]}), 64'(0));
        rc = 0; fc = 0;
        for (int k = 0; k < 20; k++) begin
            sig_a[3] = (k < 5);
            tick();
            rc += int'(rise_a[3]); fc += int'(fall_a[3]);
        end
        check("glitch5_rise", 64'(rc), 64'(1));
        check("glitch5_fall", 64'(fc), 64'(1));
        check("glitch5_level", 64'(sync_a[3]), 64'(0));

        // Channel 2: clear arriving together with the fall pulse loses to the set.
        sig_a[2] = 1'b1;
        n = 0;
        while (!sync_a[2] && n < 20) begin
            tick();
            n++;
        end
        clr_a[2] = 1'b1;
        tick();
        clr_a[2] = 1'b0;
        sig_a[2] = 1'b0;
        n = 0;
        while (!fall_a[2] && n < 20) begin
            tick();
            n++;
        end
        check("fall2_seen", 64'(fall_a[2]), 64'(1));
        clr_a[2] = 1'b1;
        tick();
        check("sticky_set_wins", 64'(fs_a[2]), 64'(1));
        tick();
        check("sticky_clear", 64'(fs_a[2]), 64'(0));
        clr_a[2] = 1'b0;

        // Channel 5: reset while the filter count is at 2.
        sig_a[5] = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        m_reset();
        #2;
        check("rst_async_a", 64'({sync_a, rise_a, fall_a, rs_a, fs_a, chg_a}), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        n = 0;
        while (!sync_a[5] && n < 20) begin
            tick();
            n++;
        end
        check("rst_restart_latency", 64'(n), 64'(6));

        // Randomized levels, glitches and clears against the model.
        for (int k = 0; k < 600; k++) begin
            mask = '0;
            for (int b = 0; b < 8; b++) mask[b] = ($urandom_range(0, 5) == 0);
            sig_a = sig_a ^ mask;
            for (int b = 0; b < 8; b++) mask[b] = ($urandom_range(0, 3) == 0);
            sig_b = sig_b ^ mask;
            clr_a = 8'($urandom & $urandom);
            clr_b = 8'($urandom & $urandom);
            if (k == 300) begin
                rst_n = 1'b0;
                m_reset();
                #2;
                check("rnd_rst_a", 64'({sync_a, rise_a, fall_a, rs_a, fs_a}), 64'(0));
                repeat (2) tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
